// File: rtl/sample_stream.sv
// Sample FIFO feeding a PWM DAC at a fixed output rate.
// Buffers upstream samples, waits for a prefill level, then pops one sample per rate tick.
module sample_stream #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CLK_DIV  = 2268,
  parameter int unsigned PREFILL  = 8,
  parameter logic [7:0]  MIDSCALE = 8'h80
) (
  input  logic                     clk,
  input  logic                     rstn_async,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic [7:0]               dac_val,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     playing,
  output logic [7:0]               underrun_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      dac_q, dac_d;
  logic [7:0]      und_q, und_d;
  logic            in_ready_q, in_ready_d;
  logic            playing_q, playing_d;
  logic            push_c, pop_c, tick_c;
  logic [7:0]      mem_q [DEPTH];

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      dac_q      <= MIDSCALE;
      und_q      <= '0;
      in_ready_q <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      dac_q      <= dac_d;
      und_q      <= und_d;
      in_ready_q <= in_ready_d;
      playing_q  <= playing_d;
    end
  end

  // Sample storage; contents are don't-care whenever the pointers are cleared
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Next-state, FIFO bookkeeping and rate counter
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    dac_d    = dac_q;
    und_d    = und_q;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    tick_c   = (cnt_q == CW'(CLK_DIV - 1));

    case (state_q)
      ST_IDLE: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
        cnt_d    = '0;
        dac_d    = MIDSCALE;
        if (en) begin
          state_d = ST_PREFILL;
        end
      end
      ST_PREFILL: begin
        push_c = in_valid && in_ready_q;
        cnt_d  = '0;
        if (level_q >= LW'(PREFILL)) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        push_c = in_valid && in_ready_q;
        cnt_d  = tick_c ? '0 : cnt_q + CW'(1);
        if (tick_c) begin
          if (level_q != '0) begin
            pop_c = 1'b1;
          end else begin
            // Empty at tick: hold the DAC and rebuild the prefill margin
            state_d = ST_PREFILL;
            if (und_q != 8'hFF) begin
              und_d = und_q + 8'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dac_d    = mem_q[rd_ptr_q];
    end
    if (push_c || pop_c) begin
      level_d = level_q + LW'(push_c) - LW'(pop_c);
    end

    // Disable overrides everything, flushing the buffer
    if (!en) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      cnt_d    = '0;
      dac_d    = MIDSCALE;
      und_d    = und_q;
      push_c   = 1'b0;
      pop_c    = 1'b0;
    end

    in_ready_d = (state_d != ST_IDLE) && (level_d != LW'(DEPTH));
    playing_d  = (state_d == ST_PLAY);
  end

  assign in_ready     = in_ready_q;
  assign dac_val      = dac_q;
  assign level        = level_q;
  assign playing      = playing_q;
  assign underrun_cnt = und_q;

endmodule

// File: tb/tb_sample_stream.sv
// Scoreboard bench for sample_stream: a fast-rate instance (CLK_DIV=4) and a slow one for fill tests.
module tb_sample_stream;

  logic       clk;
  logic       rstn;
  logic       a_en, a_valid, a_ready, a_playing;
  logic [7:0] a_data, a_dac, a_und;
  logic [4:0] a_level;
  logic       b_en, b_valid, b_ready, b_playing;
  logic [7:0] b_data, b_dac, b_und;
  logic [4:0] b_level;

  int         pass_cnt;
  int         total_cnt;
  logic [7:0] sb [$];
  logic [7:0] exp_v;
  logic [7:0] prev_v;

  sample_stream #(.DEPTH(16), .CLK_DIV(4), .PREFILL(8), .MIDSCALE(8'h80)) u_dut (
    .clk(clk), .rstn_async(rstn), .en(a_en), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .dac_val(a_dac), .level(a_level), .playing(a_playing),
    .underrun_cnt(a_und)
  );

  sample_stream #(.DEPTH(16), .CLK_DIV(64), .PREFILL(8), .MIDSCALE(8'h80)) u_slow (
    .clk(clk), .rstn_async(rstn), .en(b_en), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .dac_val(b_dac), .level(b_level), .playing(b_playing),
    .underrun_cnt(b_und)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rstn = 1'b0;
    a_en = 1'b0; a_valid = 1'b0; a_data = '0;
    b_en = 1'b0; b_valid = 1'b0; b_data = '0;
    @(negedge clk);
    total_cnt++; if (a_dac !== 8'h80) $display("FAIL reset_dac got %h want 80", a_dac); else pass_cnt++;
    total_cnt++; if (a_level !== 5'd0) $display("FAIL reset_level got %0d want 0", a_level); else pass_cnt++;
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", a_ready); else pass_cnt++;
    total_cnt++; if (a_playing !== 1'b0) $display("FAIL reset_playing got %b want 0", a_playing); else pass_cnt++;
    total_cnt++; if (a_und !== 8'd0) $display("FAIL reset_underrun got %0d want 0", a_und); else pass_cnt++;
    rstn = 1'b1;
    @(negedge clk);
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL idle_ready got %b want 0", a_ready); else pass_cnt++;
  endtask

  task automatic test_playback;
    a_en = 1'b1;
    @(negedge clk);
    total_cnt++; if (a_ready !== 1'b1 || a_playing !== 1'b0) $display("FAIL prefill_entry ready=%b playing=%b want 1/0", a_ready, a_playing); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_data = 8'h10 + 8'(i); sb.push_back(a_data);
      @(negedge clk);
    end
    a_valid = 1'b0;
    total_cnt++; if (a_level !== 5'd8 || a_playing !== 1'b0) $display("FAIL prefill_level level=%0d playing=%b want 8/0", a_level, a_playing); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_playing !== 1'b1) $display("FAIL play_start got %b want 1", a_playing); else pass_cnt++;
    prev_v = 8'h80;
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge clk);
      total_cnt++; if (a_dac !== prev_v) $display("FAIL dac_hold_%0d got %h want %h", i, a_dac, prev_v); else pass_cnt++;
      @(negedge clk);
      exp_v = sb.pop_front();
      total_cnt++; if (a_dac !== exp_v) $display("FAIL dac_pop_%0d got %h want %h", i, a_dac, exp_v); else pass_cnt++;
      prev_v = exp_v;
    end
  endtask

  task automatic test_underrun;
    repeat (2) @(negedge clk);
    total_cnt++; if (a_und !== 8'd0 || a_playing !== 1'b1) $display("FAIL pre_underrun und=%0d playing=%b want 0/1", a_und, a_playing); else pass_cnt++;
    @(negedge clk);
    // push lands in the same cycle as the empty tick
    a_valid = 1'b1; a_data = 8'h30; sb.push_back(8'h30);
    @(negedge clk);
    a_valid = 1'b0;
    total_cnt++; if (a_dac !== 8'h17) $display("FAIL underrun_dac got %h want 17", a_dac); else pass_cnt++;
    total_cnt++; if (a_und !== 8'd1) $display("FAIL underrun_cnt got %0d want 1", a_und); else pass_cnt++;
    total_cnt++; if (a_playing !== 1'b0 || a_ready !== 1'b1) $display("FAIL underrun_state playing=%b ready=%b want 0/1", a_playing, a_ready); else pass_cnt++;
    total_cnt++; if (a_level !== 5'd1) $display("FAIL underrun_push_stored got %0d want 1", a_level); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int mlvl;
    mlvl = 1;
    for (int i = 0; i < 7; i++) begin
      a_valid = 1'b1; a_data = 8'h21 + 8'(i); sb.push_back(a_data); mlvl++;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_data = 8'h28 + 8'(i); sb.push_back(a_data); mlvl++;
      @(negedge clk);
      if (i == 0) begin
        total_cnt++; if (a_playing !== 1'b1) $display("FAIL b2b_play got %b want 1", a_playing); else pass_cnt++;
      end
    end
    total_cnt++; if (a_level !== 5'(mlvl)) $display("FAIL b2b_level_before got %0d want %0d", a_level, mlvl); else pass_cnt++;
    a_valid = 1'b1; a_data = 8'h2C; sb.push_back(8'h2C);
    @(negedge clk);
    a_valid = 1'b0;
    exp_v = sb.pop_front();
    total_cnt++; if (a_level !== 5'(mlvl)) $display("FAIL b2b_level_after got %0d want %0d", a_level, mlvl); else pass_cnt++;
    total_cnt++; if (a_dac !== exp_v) $display("FAIL b2b_no_bypass got %h want %h", a_dac, exp_v); else pass_cnt++;
  endtask

  task automatic test_en_drop;
    int n;
    logic [4:0] prev_lvl;
    n = 0;
    prev_lvl = a_level;
    while (a_level !== 5'd5 && n < 60) begin
      @(negedge clk);
      n++;
      if (a_level < prev_lvl) begin
        exp_v = sb.pop_front();
        total_cnt++; if (a_dac !== exp_v) $display("FAIL drain_pop got %h want %h", a_dac, exp_v); else pass_cnt++;
      end
      prev_lvl = a_level;
    end
    total_cnt++; if (a_level !== 5'd5) $display("FAIL drain_timeout level=%0d want 5", a_level); else pass_cnt++;
    a_en = 1'b0;
    @(negedge clk);
    sb.delete();
    total_cnt++; if (a_dac !== 8'h80) $display("FAIL endrop_dac got %h want 80", a_dac); else pass_cnt++;
    total_cnt++; if (a_level !== 5'd0 || a_playing !== 1'b0 || a_ready !== 1'b0) $display("FAIL endrop_state level=%0d playing=%b ready=%b want 0/0/0", a_level, a_playing, a_ready); else pass_cnt++;
    total_cnt++; if (a_und !== 8'd1) $display("FAIL endrop_underrun got %0d want 1", a_und); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    int n;
    a_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_data = 8'h50 + 8'(i); sb.push_back(a_data);
      @(negedge clk);
    end
    a_valid = 1'b0;
    n = 0;
    while (a_dac === 8'h80 && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp_v = sb.pop_front();
    total_cnt++; if (a_dac !== exp_v) $display("FAIL rst_first_pop got %h want %h", a_dac, exp_v); else pass_cnt++;
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    total_cnt++; if (a_dac !== 8'h80 || a_level !== 5'd0) $display("FAIL async_rst_data dac=%h level=%0d want 80/0", a_dac, a_level); else pass_cnt++;
    total_cnt++; if (a_playing !== 1'b0 || a_ready !== 1'b0 || a_und !== 8'd0) $display("FAIL async_rst_ctrl playing=%b ready=%b und=%0d want 0/0/0", a_playing, a_ready, a_und); else pass_cnt++;
    sb.delete();
    @(negedge clk);
    a_en = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    total_cnt++; if (a_level !== 5'd0 || a_playing !== 1'b0) $display("FAIL post_rst level=%0d playing=%b want 0/0", a_level, a_playing); else pass_cnt++;
  endtask

  task automatic test_full;
    int   n;
    logic prev_rdy;
    b_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      b_valid = 1'b1; b_data = 8'h40 + 8'(i); sb.push_back(b_data);
      @(negedge clk);
    end
    total_cnt++; if (b_level !== 5'd16) $display("FAIL full_level got %0d want 16", b_level); else pass_cnt++;
    total_cnt++; if (b_ready !== 1'b0) $display("FAIL full_ready got %b want 0", b_ready); else pass_cnt++;
    b_valid = 1'b1; b_data = 8'hEE;
    n = 0;
    prev_rdy = b_ready;
    while (b_level === 5'd16 && n < 100) begin
      prev_rdy = b_ready;
      @(negedge clk);
      n++;
    end
    b_valid = 1'b0;
    exp_v = sb.pop_front();
    total_cnt++; if (b_level !== 5'd15) $display("FAIL full_pop level=%0d want 15", b_level); else pass_cnt++;
    total_cnt++; if (prev_rdy !== 1'b0) $display("FAIL full_ready_same_cycle got %b want 0", prev_rdy); else pass_cnt++;
    total_cnt++; if (b_ready !== 1'b1) $display("FAIL full_ready_next got %b want 1", b_ready); else pass_cnt++;
    total_cnt++; if (b_dac !== exp_v) $display("FAIL full_dac got %h want %h", b_dac, exp_v); else pass_cnt++;
    b_en = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_playback();
    test_underrun();
    test_back_to_back();
    test_en_drop();
    test_async_reset();
    test_full();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
